alu_rr_scheduler: RTL and testbench

- Shares one 8-bit ALU among NREQ requesters. The ALU provides ADD, SUB, AND, OR and AND-NOT, selected by a 3-bit select, and has a zero flag.
- Arbitration is round-robin. Each accepted operation is sequenced through a fixed IDLE -> EXEC -> RESP cycle.
- The result, zero flag and requester ID are returned on a single response channel with backpressure.
- The block drives an external combinational ALU instance. It sits between the requester agents and that ALU.

---
 rtl/alu_rr_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin arbiter that shares one external 8-bit
// combinational ALU among NREQ requesters. Each granted operation runs
// IDLE -> EXEC -> RESP and returns its result on a backpressured channel.
module alu_rr_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  input  logic [3*NREQ-1:0]    req_sel,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_sel,
  input  logic [7:0]           alu_result,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_err
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 3;
  localparam logic [SW-1:0] SEL_MAX_LEGAL = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [SW-1:0]   alu_sel_q, alu_sel_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [DW-1:0]   rsp_result_q, rsp_result_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_err_q, rsp_err_d;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic            hi_found;
  logic [IDW-1:0]  hi_idx;
  logic [IDW-1:0]  lo_idx;
  logic [DW-1:0]   gnt_a;
  logic [DW-1:0]   gnt_b;
  logic [SW-1:0]   gnt_sel;

  // Round-robin search: lowest valid index at or above rr_ptr, else lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = IDW'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    gnt_found = |req_valid;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Operand mux for the granted requester.
  always_comb begin
    gnt_a   = '0;
    gnt_b   = '0;
    gnt_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == gnt_idx) begin
        gnt_a   = req_a[i*DW +: DW];
        gnt_b   = req_b[i*DW +: DW];
        gnt_sel = req_sel[i*SW +: SW];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (gnt_found) state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: grant strobe and next values of the datapath registers.
  always_comb begin
    req_ready    = '0;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          alu_a_d   = gnt_a;
          alu_b_d   = gnt_b;
          alu_sel_d = gnt_sel;
          id_d      = gnt_idx;
          rr_ptr_d  = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
        end
      end
      S_EXEC: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_id_d     = id_q;
        rsp_err_d    = (alu_sel_q > SEL_MAX_LEGAL);
        rsp_valid_d  = 1'b1;
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      id_q         <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed testbench for alu_rr_scheduler with a behavioural ALU attached.
module tb_alu_rr_scheduler;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [3*NREQ-1:0] req_sel = '0;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [2:0]        alu_sel;
  logic [7:0]        alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  int n_vec = 0;
  int n_err = 0;

  alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // External combinational ALU.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a & ~alu_b;
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sel);
    req_a[idx*8 +: 8]   = a;
    req_b[idx*8 +: 8]   = b;
    req_sel[idx*3 +: 3] = sel;
    req_valid[idx]      = 1'b1;
  endtask

  // Single op from IDLE with rsp_ready=1; entered and left at edge+1.
  task automatic do_op(input string tag, input int idx, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] sel,
                       input logic [7:0] res, input logic zf, input logic er);
    set_req(idx, a, b, sel);
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(4'b0001 << idx));
    step();
    req_valid[idx] = 1'b0;
    #1;
    chk({tag, ".exec_ready"}, 32'(req_ready), 32'h0);
    step();
    chk({tag, ".valid"},  32'(rsp_valid),  32'h1);
    chk({tag, ".result"}, 32'(rsp_result), 32'(res));
    chk({tag, ".zero"},   32'(rsp_zero),   32'(zf));
    chk({tag, ".id"},     32'(rsp_id),     32'(idx));
    chk({tag, ".err"},    32'(rsp_err),    32'(er));
    step();
    chk({tag, ".done"},   32'(rsp_valid),  32'h0);
  endtask

  logic [7:0] exp_res [4];

  initial begin
    // Reset: everything cleared, no grant even with all requests valid.
    rst = 1'b1;
    req_valid = 4'b1111;
    step();
    step();
    chk("rst.ready",     32'(req_ready),  32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid),  32'h0);
    chk("rst.alu_a",     32'(alu_a),      32'h0);
    chk("rst.alu_sel",   32'(alu_sel),    32'h0);
    chk("rst.result",    32'(rsp_result), 32'h0);
    req_valid = '0;
    rst = 1'b0;
    step();

    // 1. Single op from requester 1.
    set_req(1, 8'd5, 8'd3, 3'b000);
    #1;
    chk("t1.ready", 32'(req_ready), 32'h2);
    step();
    req_valid[1] = 1'b0;
    #1;
    chk("t1.exec_ready", 32'(req_ready), 32'h0);
    chk("t1.alu_a",      32'(alu_a),     32'd5);
    chk("t1.alu_b",      32'(alu_b),     32'd3);
    chk("t1.exec_valid", 32'(rsp_valid), 32'h0);
    step();
    chk("t1.valid",  32'(rsp_valid),  32'h1);
    chk("t1.result", 32'(rsp_result), 32'd8);
    chk("t1.zero",   32'(rsp_zero),   32'h0);
    chk("t1.id",     32'(rsp_id),     32'd1);
    chk("t1.err",    32'(rsp_err),    32'h0);
    step();
    chk("t1.done", 32'(rsp_valid), 32'h0);

    // 2. Contention after reset: grants 0,1,2,3,0 every 3 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 8'd10,  8'd20,  3'b000); exp_res[0] = 8'd30;
    set_req(1, 8'd50,  8'd60,  3'b001); exp_res[1] = 8'hF6;
    set_req(2, 8'hF0,  8'h3C,  3'b010); exp_res[2] = 8'h30;
    set_req(3, 8'h0F,  8'h30,  3'b011); exp_res[3] = 8'h3F;
    for (int g = 0; g < 5; g++) begin
      int e;
      e = g % 4;
      #1;
      chk("t2.grant", 32'(req_ready), 32'(4'b0001 << e));
      step();
      step();
      chk("t2.rsp_id",     32'(rsp_id),     32'(e));
      chk("t2.rsp_result", 32'(rsp_result), 32'(exp_res[e]));
      step();
    end
    req_valid = '0;

    // 3. Zero flag.
    do_op("t3.sub0",   2, 8'd8,  8'd8,  3'b001, 8'h00, 1'b1, 1'b0);
    do_op("t3.andnot", 0, 8'hCC, 8'hAA, 3'b100, 8'h44, 1'b0, 1'b0);

    // 4. Backpressure for 5 cycles, with requester 3 waiting.
    rsp_ready = 1'b0;
    set_req(2, 8'd7, 8'd9, 3'b000);
    step();
    req_valid[2] = 1'b0;
    set_req(3, 8'd1, 8'd2, 3'b011);
    step();
    for (int c = 0; c < 5; c++) begin
      chk("t4.hold_valid",  32'(rsp_valid),  32'h1);
      chk("t4.hold_result", 32'(rsp_result), 32'h10);
      chk("t4.hold_id",     32'(rsp_id),     32'd2);
      chk("t4.hold_ready",  32'(req_ready),  32'h0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("t4.release_ready", 32'(req_ready), 32'h0);
    step();
    chk("t4.idle_valid", 32'(rsp_valid), 32'h0);
    chk("t4.next_grant", 32'(req_ready), 32'h8);
    step();
    req_valid[3] = 1'b0;
    step();
    chk("t4.next_result", 32'(rsp_result), 32'h03);
    chk("t4.next_id",     32'(rsp_id),     32'd3);
    step();

    // 5. Unsupported select, then a legal op.
    do_op("t5.illegal", 1, 8'hFF, 8'h01, 3'b111, 8'h00, 1'b1, 1'b1);
    do_op("t5.legal",   1, 8'd3,  8'd5,  3'b001, 8'hFE, 1'b0, 1'b0);

    // 6. Reset during EXEC abandons the op and rewinds the pointer.
    set_req(2, 8'd4, 8'd4, 3'b000);
    step();
    req_valid[2] = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t6.alu_a",     32'(alu_a),     32'h0);
    chk("t6.alu_b",     32'(alu_b),     32'h0);
    chk("t6.alu_sel",   32'(alu_sel),   32'h0);
    step();
    chk("t6.no_rsp", 32'(rsp_valid), 32'h0);
    set_req(3, 8'd1, 8'd1, 3'b000);
    set_req(0, 8'd6, 8'd1, 3'b001);
    #1;
    chk("t6.grant0", 32'(req_ready), 32'h1);
    step();
    req_valid[0] = 1'b0;
    step();
    chk("t6.id",     32'(rsp_id),     32'd0);
    chk("t6.result", 32'(rsp_result), 32'd5);
    step();
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
